// File: rtl/icache_2way_fill.sv
// icache_2way_fill: 2-way set-associative read-only instruction cache with an
// in-order block-fill controller, per-set LRU bit and whole-cache flush.
// Optional build macro ICACHE_PERF_EN adds the hit_cnt/miss_cnt counters.
//
// state | meaning
// IDLE  | combinational lookup; a miss starts a fill, flush starts a flush
// FILL  | stream one block from memory into the victim way
// FLUSH | single cycle clearing every valid and LRU bit
module icache_2way_fill #(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              flush,
    input  logic [15:0]       mem_data,
    input  logic              mem_data_valid,
    output logic [15:0]       data_out,
    output logic              hit,
    output logic              stall,
    output logic              mem_read_req,
    output logic [ADDR_W-1:0] mem_addr
`ifdef ICACHE_PERF_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W - 1;
    localparam int NSETS  = 2 ** INDEX_W;
    localparam int NWORDS = 2 ** OFFSET_W;
    localparam logic [OFFSET_W:0]   ISSUE_ONE = 1;
    localparam logic [OFFSET_W-1:0] RET_ONE   = 1;
    localparam logic [OFFSET_W-1:0] RET_LAST  = OFFSET_W'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [INDEX_W-1:0]  fill_idx_q, fill_idx_d;
    logic                victim_q, victim_d;
    logic [OFFSET_W:0]   issue_cnt_q, issue_cnt_d;
    logic [OFFSET_W-1:0] ret_cnt_q, ret_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic [NSETS-1:0]    vld0_q, vld0_d, vld1_q, vld1_d, lru_q, lru_d;

    logic [TAG_W-1:0]    tag_mem  [2][NSETS];
    logic [15:0]         data_mem [2][NSETS][NWORDS];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic                way0_match, way1_match, busy, beat;
    logic                data_we, tag_we, victim_sel;
    logic                unused_addr_lsb;

    // Fetches are word aligned; the byte-lane bit carries no information.
    assign unused_addr_lsb = addr_in[0];

    assign req_tag = addr_in[ADDR_W-1 -: TAG_W];
    assign req_idx = addr_in[OFFSET_W+INDEX_W:OFFSET_W+1];
    assign req_off = addr_in[OFFSET_W:1];

    assign way0_match = vld0_q[req_idx] && (tag_mem[0][req_idx] == req_tag);
    assign way1_match = vld1_q[req_idx] && (tag_mem[1][req_idx] == req_tag);
    assign busy       = (state_q != IDLE);
    assign hit        = rd_req && !busy && (way0_match || way1_match);
    assign stall      = busy || (rd_req && !hit);
    assign data_out   = !hit       ? 16'h0000 :
                        way0_match ? data_mem[0][req_idx][req_off] :
                                     data_mem[1][req_idx][req_off];

    assign mem_read_req = (state_q == FILL) && !issue_cnt_q[OFFSET_W];
    assign mem_addr     = mem_read_req ?
                          {fill_tag_q, fill_idx_q, issue_cnt_q[OFFSET_W-1:0], 1'b0} : '0;
    assign beat         = (state_q == FILL) && mem_data_valid;

    // Next-state, fill bookkeeping and valid/LRU updates.
    always_comb begin
        state_d      = state_q;
        fill_tag_d   = fill_tag_q;
        fill_idx_d   = fill_idx_q;
        victim_d     = victim_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        flush_pend_d = flush_pend_q;
        vld0_d       = vld0_q;
        vld1_d       = vld1_q;
        lru_d        = lru_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        victim_sel   = !vld0_q[req_idx] ? 1'b0 :
                       !vld1_q[req_idx] ? 1'b1 : lru_q[req_idx];
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (rd_req && !(way0_match || way1_match)) begin
                    state_d      = FILL;
                    fill_tag_d   = req_tag;
                    fill_idx_d   = req_idx;
                    victim_d     = victim_sel;
                    issue_cnt_d  = '0;
                    ret_cnt_d    = '0;
                    flush_pend_d = 1'b0;
                    // The victim must not hit while only partly refilled.
                    if (victim_sel) vld1_d[req_idx] = 1'b0;
                    else            vld0_d[req_idx] = 1'b0;
                end else if (hit) begin
                    lru_d[req_idx] = way0_match;
                end
            end
            FILL: begin
                if (mem_read_req) issue_cnt_d = issue_cnt_q + ISSUE_ONE;
                if (flush)        flush_pend_d = 1'b1;
                if (beat) begin
                    data_we   = 1'b1;
                    ret_cnt_d = ret_cnt_q + RET_ONE;
                    if (ret_cnt_q == RET_LAST) begin
                        tag_we = 1'b1;
                        if (victim_q) vld1_d[fill_idx_q] = 1'b1;
                        else          vld0_d[fill_idx_q] = 1'b1;
                        lru_d[fill_idx_q] = !victim_q;
                        state_d = (flush_pend_q || flush) ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                vld0_d  = '0;
                vld1_d  = '0;
                lru_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and per-set state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
            victim_q     <= 1'b0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            vld0_q       <= '0;
            vld1_q       <= '0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            fill_tag_q   <= fill_tag_d;
            fill_idx_q   <= fill_idx_d;
            victim_q     <= victim_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            flush_pend_q <= flush_pend_d;
            vld0_q       <= vld0_d;
            vld1_q       <= vld1_d;
            lru_q        <= lru_d;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[victim_q][fill_idx_q][ret_cnt_q] <= mem_data;
        if (tag_we)  tag_mem[victim_q][fill_idx_q] <= fill_tag_q;
    end

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        miss_start;

    assign miss_start = (state_q == IDLE) && (state_d == FILL);

    // Saturating hit/miss counters; a miss counts once, when its fill starts.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && hit_cnt_q != 16'hFFFF)         hit_cnt_d  = hit_cnt_q + 16'h0001;
        if (miss_start && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'h0001;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_2way_fill.sv
// Bench for icache_2way_fill: memory responder with 4-cycle return, an
// LRU-list cache model, and scoreboards for fetched data and fill addresses.
module tb_icache_2way_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] addr_in = 16'h0000;
    logic        flush = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_data_valid = 1'b0;
    logic [15:0] data_out;
    logic        hit, stall, mem_read_req;
    logic [15:0] mem_addr;
`ifdef ICACHE_PERF_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    icache_2way_fill #(.ADDR_W(16), .INDEX_W(6), .OFFSET_W(3)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .addr_in(addr_in), .flush(flush),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid), .data_out(data_out),
        .hit(hit), .stall(stall), .mem_read_req(mem_read_req), .mem_addr(mem_addr)
`ifdef ICACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- main memory and responder ----------------
    typedef struct { int due; logic [15:0] d; } ret_t;
    logic [15:0] mem [0:32767];
    ret_t        pend [$];
    ret_t        r_tmp;
    logic [15:0] exp_addr [$];
    logic [15:0] ea_tmp;

    // Capture each request, check its address, schedule its word 4 cycles later.
    always @(negedge clk) begin
        if (mem_read_req) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL mem_addr_unexpected got %h expected none", mem_addr);
            end else begin
                ea_tmp = exp_addr.pop_front();
                if (mem_addr !== ea_tmp) begin
                    errors++;
                    $display("FAIL mem_addr got %h expected %h", mem_addr, ea_tmp);
                end
            end
            r_tmp.due = cyc + 4;
            r_tmp.d   = mem[mem_addr[15:1]];
            pend.push_back(r_tmp);
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = pend[0].d;
            void'(pend.pop_front());
        end else begin
            mem_data_valid = 1'b0;
            mem_data       = 16'($urandom);
        end
    end

    // ---------------- fetched-data scoreboard ----------------
    logic [15:0] sb [$];
    logic [15:0] sb_tmp;

    always @(negedge clk) begin
        if (rst) begin
            if (hit) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_hit addr %h data %h expected no hit", addr_in, data_out);
                end else begin
                    sb_tmp = sb.pop_front();
                    if (data_out !== sb_tmp) begin
                        errors++;
                        $display("FAIL data_out addr %h got %h expected %h", addr_in, data_out, sb_tmp);
                    end
                end
            end else if (data_out !== 16'h0000) begin
                checks++;
                errors++;
                $display("FAIL data_out_idle got %h expected 0000", data_out);
            end
        end
    end

    // ---------------- reference model: per-set list, MRU first ----------------
    int          n_res [64];
    logic [5:0]  rtag  [64][2];
    logic [15:0] rdat  [64][2][8];

    task automatic model_clear();
        for (int s = 0; s < 64; s++) n_res[s] = 0;
    endtask

    task automatic push_fill_addrs(input logic [15:0] a);
        for (int w = 0; w < 8; w++) exp_addr.push_back({a[15:4], 4'(2 * w)});
    endtask

    task automatic model_access(input logic [15:0] a, output bit h, output logic [15:0] d);
        int s = int'(a[9:4]);
        logic [5:0] tg = a[15:10];
        int off = int'(a[3:1]);
        int slot = -1;
        for (int k = 0; k < n_res[s]; k++) if (rtag[s][k] == tg) slot = k;
        h = (slot >= 0);
        if (h) begin
            if (slot == 1) begin
                rtag[s][1] = rtag[s][0];
                rtag[s][0] = tg;
                for (int w = 0; w < 8; w++) begin
                    logic [15:0] t = rdat[s][0][w];
                    rdat[s][0][w] = rdat[s][1][w];
                    rdat[s][1][w] = t;
                end
            end
        end else begin
            if (n_res[s] >= 1) begin
                rtag[s][1] = rtag[s][0];
                for (int w = 0; w < 8; w++) rdat[s][1][w] = rdat[s][0][w];
            end
            n_res[s] = (n_res[s] == 2) ? 2 : n_res[s] + 1;
            rtag[s][0] = tg;
            for (int w = 0; w < 8; w++) rdat[s][0][w] = mem[{a[15:4], 3'(w)}];
            push_fill_addrs(a);
            exp_miss++;
        end
        exp_hits++;
        d = rdat[s][0][off];
    endtask

    // ---------------- stimulus tasks (enter and leave at posedge+1) ----------------
    task automatic fetch(input logic [15:0] a, output int lat);
        bit          ph;
        logic [15:0] ed;
        model_access(a, ph, ed);
        sb.push_back(ed);
        rd_req  = 1'b1;
        addr_in = a;
        lat = 0;
        @(negedge clk);
        chk("first_hit", hit, ph);
        chk("first_stall", stall, !ph);
        while (!hit && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("fetch_done", hit, 1'b1);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_stall", stall, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", stall, 1'b1);
        @(negedge clk);
        chk("flush_done", stall, 1'b0);
        @(posedge clk); #1;
        model_clear();
    endtask

    task automatic wait_beats(input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 100) begin
            @(negedge clk);
            if (mem_data_valid) seen++;
            k++;
        end
        chk("beats_seen", seen, n);
    endtask

    task automatic check_counters();
`ifdef ICACHE_PERF_EN
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_miss);
`endif
    endtask

    int lat;
    logic [15:0] ra;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        model_clear();
        #12;
        chk("rst_hit", hit, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_read_req", mem_read_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_data_out", data_out, 16'h0000);
        check_counters();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // cold miss: 8 requests, hit the cycle after the 8th word
        fetch(16'h0040, lat);
        chk("miss_latency", lat, 13);
        fetch(16'h0046, lat);
        chk("hit_latency", lat, 0);

        // LRU replacement in set 4
        fetch(16'h0440, lat);
        fetch(16'h0040, lat);
        fetch(16'h0840, lat);
        fetch(16'h0040, lat);
        fetch(16'h0440, lat);
        check_counters();

        // flush while idle
        flush_idle();
        check_counters();
        fetch(16'h0040, lat);
        chk("refill_latency", lat, 13);

        // flush pulsed on fill beat 3: fill completes, then everything is dropped
        rd_req = 1'b1;
        addr_in = 16'h0C40;
        push_fill_addrs(16'h0C40);
        exp_miss++;
        @(posedge clk); #1;
        rd_req = 1'b0;
        wait_beats(2);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (stall && lat < 100);
        chk("flush_in_fill_end", stall, 1'b0);
        chk("flush_in_fill_addrs", exp_addr.size(), 0);
        @(posedge clk); #1;
        model_clear();
        check_counters();
        fetch(16'h0040, lat);

        // reset after three fill beats
        rd_req = 1'b1;
        addr_in = 16'h2080;
        push_fill_addrs(16'h2080);
        @(posedge clk); #1;
        rd_req = 1'b0;
        wait_beats(3);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_fill_mem_read_req", mem_read_req, 1'b0);
        chk("rst_fill_stall", stall, 1'b0);
        exp_addr.delete();
        sb.delete();
        model_clear();
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk); #2;
        rst = 1'b1;
        lat = 0;
        while (pend.size() > 0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("late_beats_stall", stall, 1'b0);
        chk("late_beats_req", mem_read_req, 1'b0);
        fetch(16'h0040, lat);
        chk("post_rst_latency", lat, 13);
        for (int w = 1; w < 7; w++) fetch(16'h0040 + 16'(2 * w), lat);
        check_counters();
        flush_idle();
        check_counters();

        // random traffic over a few tags and sets, with memory rewrites and flushes
        for (int n = 0; n < 250; n++) begin
            ra = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0};
            if ($urandom_range(0, 4) == 0) mem[ra[15:1]] = 16'($urandom);
            if ($urandom_range(0, 19) == 0) flush_idle();
            fetch(ra, lat);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        check_counters();
        chk("sb_empty", sb.size(), 0);
        chk("addr_q_empty", exp_addr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
